// File: rtl/regdst_mux_stage.sv
// Destination-register select stage: NUM_IN:1 candidate mux feeding a registered
// valid/ready output with a one-entry skid buffer and flush. Optional macro: REGDST_SEL_RANGE_CHECK_EN.

module regdst_mux_cand #(
   parameter int WIDTH  = 5,
   parameter int SEL_W  = 2,
   parameter int NUM_IN = 4,
   parameter int IDX    = 0
) (
   input  logic [WIDTH-1:0] cand,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] masked
);
   logic hit;

   // Candidate 0 also absorbs every out-of-range select.
   generate
      if (IDX == 0) begin : g_zero
         assign hit = (sel == '0) || ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
      end else begin : g_other
         assign hit = (sel == SEL_W'(IDX));
      end
   endgenerate

   assign masked = hit ? cand : '0;
endmodule

module regdst_mux_stage #(
   parameter int WIDTH  = 5,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   input  logic                    flush,
   output logic [1:0]              occupancy,
   output logic                    sel_err
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL1 = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t                         state, nxt;
   logic [NUM_IN-1:0][WIDTH-1:0]   masked;
   logic [WIDTH-1:0]               sel_data;
   logic [WIDTH-1:0]               skid_data;
   logic                           acc, take;
   logic                           ld_sel, ld_skid, ld_from_skid;

   genvar k;
   generate
      for (k = 0; k < NUM_IN; k++) begin : g_cand
         regdst_mux_cand #(
            .WIDTH (WIDTH),
            .SEL_W (SEL_W),
            .NUM_IN(NUM_IN),
            .IDX   (k)
         ) u_cand (
            .cand  (in_bus[k*WIDTH +: WIDTH]),
            .sel   (in_sel),
            .masked(masked[k])
         );
      end
   endgenerate

   // Exactly one candidate is unmasked, so an OR reduction is the mux.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_IN; i++) sel_data = sel_data | masked[i];
   end

   assign in_ready  = (state != SKID);
   assign out_valid = (state != EMPTY);
   assign occupancy = state;
   assign acc       = in_valid && in_ready;
   assign take      = acc && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= nxt;
   end

   always_comb begin
      nxt          = state;
      ld_sel       = 1'b0;
      ld_skid      = 1'b0;
      ld_from_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (take) begin
               nxt    = FULL1;
               ld_sel = 1'b1;
            end
         end
         FULL1: begin
            if (take && out_ready) begin
               ld_sel = 1'b1;
            end else if (take) begin
               nxt     = SKID;
               ld_skid = 1'b1;
            end else if (out_ready) begin
               nxt = EMPTY;
            end
         end
         SKID: begin
            if (out_ready) begin
               nxt          = FULL1;
               ld_from_skid = 1'b1;
            end
         end
         default: nxt = EMPTY;
      endcase
      // Squash wins; an output handshake this cycle has already been delivered.
      if (flush) begin
         nxt          = EMPTY;
         ld_from_skid = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         skid_data <= '0;
      end else begin
         if (ld_sel)            out_data <= sel_data;
         else if (ld_from_skid) out_data <= skid_data;
         if (ld_skid)           skid_data <= sel_data;
      end
   end

`ifdef REGDST_SEL_RANGE_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                    sel_err <= 1'b0;
      else if (acc && ({1'b0, in_sel} >= (SEL_W+1)'(NUM_IN)))     sel_err <= 1'b1;
   end
`else
   assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_regdst_mux_stage.sv
// Bench for regdst_mux_stage: directed test-plan steps followed by random traffic,
// checked against a queue-based model of the held beats.

module tb_regdst_mux_stage;
   localparam int WIDTH  = 5;
   localparam int NUM_IN = 4;
   localparam int SEL_W  = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_IN*WIDTH-1:0] in_bus;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic                    flush;
   logic [1:0]              occupancy;
   logic                    sel_err;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] cand [NUM_IN];
   logic [WIDTH-1:0] q [$];

   regdst_mux_stage #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst), .in_bus(in_bus), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .flush(flush), .occupancy(occupancy), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   task automatic pack();
      for (int i = 0; i < NUM_IN; i++) in_bus[i*WIDTH +: WIDTH] = cand[i];
   endtask

   function automatic logic [WIDTH-1:0] pick(input int s);
      if (s < NUM_IN) return cand[s];
      return cand[0];
   endfunction

   task automatic set_cands(input int c0, input int c1, input int c2, input int c3);
      cand[0] = WIDTH'(c0); cand[1] = WIDTH'(c1); cand[2] = WIDTH'(c2); cand[3] = WIDTH'(c3);
      pack();
   endtask

   task automatic drive(input bit v, input int s, input bit ordy, input bit fl);
      in_valid = v; in_sel = SEL_W'(s); out_ready = ordy; flush = fl;
   endtask

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(q.size() != 0));
      chk({tag, ".in_ready"},  WIDTH'(in_ready),  WIDTH'(q.size() < 2));
      chk({tag, ".occupancy"}, WIDTH'(occupancy), WIDTH'(q.size()));
      chk({tag, ".sel_err"},   WIDTH'(sel_err),   '0);
      if (q.size() != 0) chk({tag, ".out_data"}, out_data, q[0]);
   endtask

   // Model: a FIFO of at most two beats; delivery happens before a new beat joins.
   task automatic model_edge();
      bit dq, ac;
      logic [WIDTH-1:0] v;
      dq = (q.size() != 0) && out_ready;
      ac = in_valid && (q.size() < 2);
      v  = pick(int'(in_sel));
      if (dq) void'(q.pop_front());
      if (flush) q.delete();
      else if (ac) q.push_back(v);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0);
      set_cands(3, 7, 12, 31);
      #3;
      chk("reset.out_valid", WIDTH'(out_valid), '0);
      chk("reset.out_data",  out_data, '0);
      chk("reset.in_ready",  WIDTH'(in_ready), WIDTH'(1));
      chk("reset.occupancy", WIDTH'(occupancy), '0);
      chk("reset.sel_err",   WIDTH'(sel_err), '0);
      @(negedge clk);
      rst = 1'b0;
      step("idle");

      // Stream at full rate
      drive(1, 1, 1, 0); step("stream1"); chk("stream1.val", out_data, WIDTH'(7));
      drive(1, 2, 1, 0); step("stream2"); chk("stream2.val", out_data, WIDTH'(12));
      drive(1, 3, 1, 0); step("stream3"); chk("stream3.val", out_data, WIDTH'(31));
      drive(0, 0, 1, 0); step("stream_drain");

      // Stall fill then drain in order
      drive(1, 0, 1, 0); step("fill1");
      drive(1, 1, 0, 0); step("fill2");
      chk("fill2.occ", WIDTH'(occupancy), WIDTH'(2));
      chk("fill2.head", out_data, WIDTH'(3));
      drive(1, 2, 0, 0); step("fill_hold");
      drive(0, 0, 1, 0); step("drain1");
      chk("drain1.head", out_data, WIDTH'(7));
      chk("drain1.in_ready", WIDTH'(in_ready), WIDTH'(1));
      drive(0, 0, 1, 0); step("drain2");

      // Flush while the skid is occupied; the offered beat is dropped
      drive(1, 0, 0, 0); step("fl_fill1");
      drive(1, 1, 0, 0); step("fl_fill2");
      drive(1, 3, 0, 1); step("flush");
      chk("flush.occ", WIDTH'(occupancy), '0);
      drive(0, 0, 1, 0); step("post_flush");

      // Captured value ignores later input changes
      drive(1, 2, 0, 0); step("cap");
      set_cands(1, 2, 4, 8);
      drive(0, 0, 0, 0); step("cap_hold");
      chk("cap_hold.val", out_data, WIDTH'(12));
      drive(1, 3, 0, 0); step("cap_skid");
      drive(0, 1, 0, 0); step("cap_hold2");

      // Asynchronous reset with two beats held
      @(negedge clk);
      rst = 1'b1;
      #1;
      q.delete();
      chk("midrst.out_valid", WIDTH'(out_valid), '0);
      chk("midrst.out_data",  out_data, '0);
      chk("midrst.in_ready",  WIDTH'(in_ready), WIDTH'(1));
      chk("midrst.occupancy", WIDTH'(occupancy), '0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 1, 0); step("post_rst");

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NUM_IN; i++) cand[i] = WIDTH'($urandom);
         pack();
         drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
               bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 15) == 0));
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
